// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock/reset control and status bundle for pll_reset_sequencer
interface pll_reset_sequencer_if;
   logic       pll_locked_i;
   logic       relock_i;
   logic       pll_rst_o;
   logic       rst_core_o;
   logic       rst_ddr_o;
   logic       ready_o;
   logic [7:0] retry_count_o;
   logic       fail_o;

   // Controller side: supplies lock status and relock requests, observes resets.
   modport master (
      output pll_locked_i,
      output relock_i,
      input  pll_rst_o,
      input  rst_core_o,
      input  rst_ddr_o,
      input  ready_o,
      input  retry_count_o,
      input  fail_o
   );

   // Sequencer side.
   modport slave (
      input  pll_locked_i,
      input  relock_i,
      output pll_rst_o,
      output rst_core_o,
      output rst_ddr_o,
      output ready_o,
      output retry_count_o,
      output fail_o
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, core/DDR reset release (option: PLL_RESET_SEQ_AUTO_RETRY_EN)
module pll_reset_sequencer #(
   parameter int unsigned POR_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 100000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned DDR_DELAY     = 256,
   parameter int unsigned CNT_W         = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   pll_reset_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_CORE_ON   = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_ANY = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DDR_LAST    = CNT_W'(DDR_DELAY - 1);

`ifdef PLL_RESET_SEQ_AUTO_RETRY_EN
   localparam state_e TIMEOUT_DEST = S_PLL_RST;
`else
   localparam state_e TIMEOUT_DEST = S_FAIL;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic             retry_inc;
   logic             sync1_q, lk_s_q;
   logic             pll_rst_q, pll_rst_d;
   logic             core_q, core_d;
   logic             ddr_q, ddr_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;

   // Two-flop synchronizer bringing PLL LOCKED into the reference clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         lk_s_q  <= 1'b0;
      end else begin
         sync1_q <= bus.pll_locked_i;
         lk_s_q  <= sync1_q;
      end
   end

   // State, counter, retry count and registered output decodes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_PLL_RST;
         cnt_q     <= '0;
         retry_q   <= 8'd0;
         pll_rst_q <= 1'b1;
         core_q    <= 1'b1;
         ddr_q     <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         core_q    <= core_d;
         ddr_q     <= ddr_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   // Next-state selection; relock wins over lock loss and timeout, except in PLL_RST and FAIL.
   always_comb begin
      state_d   = state_q;
      retry_inc = 1'b0;
      unique case (state_q)
         S_PLL_RST: begin
            if (cnt_q == POR_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (bus.relock_i) begin
               state_d = S_PLL_RST;
            end else if (lk_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_ANY) begin
               state_d   = TIMEOUT_DEST;
               retry_inc = 1'b1;
            end
         end
         S_STABLE: begin
            if (bus.relock_i) begin
               state_d = S_PLL_RST;
            end else if (!lk_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_CORE_ON;
            end
         end
         S_CORE_ON: begin
            if (bus.relock_i) begin
               state_d = S_PLL_RST;
            end else if (!lk_s_q) begin
               state_d   = S_PLL_RST;
               retry_inc = 1'b1;
            end else if (cnt_q == DDR_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.relock_i) begin
               state_d = S_PLL_RST;
            end else if (!lk_s_q) begin
               state_d   = S_PLL_RST;
               retry_inc = 1'b1;
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_PLL_RST;
         end
      endcase

      // Counter restarts on every state entry and idles where nothing is timed.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_RUN || state_q == S_FAIL) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
   end

   // Moore output decode of the state being entered, so outputs track the state register exactly.
   always_comb begin
      pll_rst_d = 1'b1;
      core_d    = 1'b1;
      ddr_d     = 1'b1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      unique case (state_d)
         S_PLL_RST: begin
            pll_rst_d = 1'b1;
         end
         S_WAIT_LOCK, S_STABLE: begin
            pll_rst_d = 1'b0;
         end
         S_CORE_ON: begin
            pll_rst_d = 1'b0;
            core_d    = 1'b0;
         end
         S_RUN: begin
            pll_rst_d = 1'b0;
            core_d    = 1'b0;
            ddr_d     = 1'b0;
            ready_d   = 1'b1;
         end
         S_FAIL: begin
`ifdef PLL_RESET_SEQ_AUTO_RETRY_EN
            fail_d = 1'b0;
`else
            fail_d = 1'b1;
`endif
         end
         default: begin
            pll_rst_d = 1'b1;
         end
      endcase
   end

   assign bus.pll_rst_o     = pll_rst_q;
   assign bus.rst_core_o    = core_q;
   assign bus.rst_ddr_o     = ddr_q;
   assign bus.ready_o       = ready_q;
   assign bus.retry_count_o = retry_q;
   assign bus.fail_o        = fail_q;

endmodule
